// File: rtl/operand_stack_pkg.sv
// Shared constants and the decoded operation type for the operand stack.
package stack_pkg;

    localparam int STACK_DATA_W = 8;
    localparam int STACK_DEPTH  = 16;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_PUSH,
        OP_POP,
        OP_TOS,
        OP_REPLACE
    } stack_op_e;

endpackage

// File: rtl/operand_stack_ram.sv
// Stack storage: DEPTH x DATA_W array, one synchronous write port, one combinational read port.
module stack_ram
    import stack_pkg::*;
#(
    parameter int DATA_W = STACK_DATA_W,
    parameter int DEPTH  = STACK_DEPTH,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Unused address codes (non power-of-two depth) read as zero rather than X.
    always_comb begin
        rdata = '0;
        if (int'(raddr) < DEPTH) begin
            rdata = mem[raddr];
        end
    end

endmodule

// File: rtl/operand_stack.sv
// Operand stack with registered top-of-stack read and overflow/underflow reporting.
// Define OPSTACK_ERR_STICKY_EN to make ovf/unf sticky until err_clr; otherwise they are 1-cycle pulses.
module operand_stack
    import stack_pkg::*;
#(
    parameter int DATA_W = STACK_DATA_W,
    parameter int DEPTH  = STACK_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       tos,
    input  logic [DATA_W-1:0]          din,
    input  logic                       err_clr,
    output logic [DATA_W-1:0]          dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       ovf,
    output logic                       unf
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int AW    = $clog2(DEPTH);

    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              ovf_evt, unf_evt;

    logic [CNT_W-1:0]  top_idx;
    logic              ram_we;
    logic [AW-1:0]     ram_waddr;
    logic [DATA_W-1:0] ram_rdata;
    stack_op_e         op;

    assign top_idx = count_q - CNT_W'(1);
    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));

    stack_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (din),
        .raddr (top_idx[AW-1:0]),
        .rdata (ram_rdata)
    );

    always_comb begin
        unique case ({push, pop})
            2'b10:   op = OP_PUSH;
            2'b01:   op = OP_POP;
            2'b11:   op = OP_REPLACE;
            default: op = tos ? OP_TOS : OP_NONE;
        endcase
    end

    always_comb begin
        count_d   = count_q;
        dout_d    = dout_q;
        ram_we    = 1'b0;
        ram_waddr = count_q[AW-1:0];
        ovf_evt   = 1'b0;
        unf_evt   = 1'b0;
        unique case (op)
            OP_PUSH: begin
                if (full) begin
                    ovf_evt = 1'b1;
                end else begin
                    ram_we  = 1'b1;
                    count_d = count_q + CNT_W'(1);
                end
            end
            OP_POP: begin
                if (empty) begin
                    unf_evt = 1'b1;
                end else begin
                    dout_d  = ram_rdata;
                    count_d = top_idx;
                end
            end
            OP_TOS: begin
                if (empty) begin
                    unf_evt = 1'b1;
                end else begin
                    dout_d = ram_rdata;
                end
            end
            OP_REPLACE: begin
                // On an empty stack the push half still lands in slot 0.
                ram_we = 1'b1;
                if (empty) begin
                    unf_evt   = 1'b1;
                    ram_waddr = '0;
                    count_d   = CNT_W'(1);
                end else begin
                    ram_waddr = top_idx[AW-1:0];
                    dout_d    = ram_rdata;
                end
            end
            default: ;
        endcase
    end

`ifdef OPSTACK_ERR_STICKY_EN
    // A new event in the same cycle as err_clr keeps the flag set.
    assign ovf_d = ovf_evt | (ovf_q & ~err_clr);
    assign unf_d = unf_evt | (unf_q & ~err_clr);
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign ovf_d = ovf_evt;
    assign unf_d = unf_evt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            dout_q  <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            dout_q  <= dout_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign dout  = dout_q;
    assign count = count_q;
    assign ovf   = ovf_q;
    assign unf   = unf_q;

endmodule

// File: tb/tb_operand_stack.sv
// Self-checking bench for operand_stack: table of vectors plus hand-written corner sequences.
module tb_operand_stack;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          push = 1'b0, pop = 1'b0, tos = 1'b0, err_clr = 1'b0;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] dout;
    logic [CW-1:0] count;
    logic          empty, full, ovf, unf;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [DW-1:0] dout;
        logic [CW-1:0] count;
        logic          empty, full, ovf, unf;
    } exp_t;

    typedef struct {
        logic          push, pop, tos, clr;
        logic [DW-1:0] din;
        exp_t          e;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];

    operand_stack #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .tos     (tos),
        .din     (din),
        .err_clr (err_clr),
        .dout    (dout),
        .count   (count),
        .empty   (empty),
        .full    (full),
        .ovf     (ovf),
        .unf     (unf)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic p, input logic pp, input logic t, input logic c,
                                input logic [DW-1:0] d, input logic [DW-1:0] od,
                                input int oc, input logic oe, input logic of,
                                input logic oo, input logic ou);
        vec_t v;
        v.push = p; v.pop = pp; v.tos = t; v.clr = c; v.din = d;
        v.e.dout = od; v.e.count = CW'(oc); v.e.empty = oe; v.e.full = of;
        v.e.ovf = oo; v.e.unf = ou;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty got dout %0h expected entry", tag, dout);
            return;
        end
        e = sb.pop_front();
        chk({tag, " dout"},  32'(dout),  32'(e.dout));
        chk({tag, " count"}, 32'(count), 32'(e.count));
        chk({tag, " empty"}, 32'(empty), 32'(e.empty));
        chk({tag, " full"},  32'(full),  32'(e.full));
        chk({tag, " ovf"},   32'(ovf),   32'(e.ovf));
        chk({tag, " unf"},   32'(unf),   32'(e.unf));
    endtask

    task automatic step(input vec_t v, input string tag);
        @(negedge clk);
        push = v.push; pop = v.pop; tos = v.tos; err_clr = v.clr; din = v.din;
        sb.push_back(v.e);
        @(posedge clk);
        #1;
        compare_out(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        push = 1'b0; pop = 1'b0; tos = 1'b0; err_clr = 1'b0; din = '0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        push = 1'b0; pop = 1'b0; tos = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset count", 32'(count), 32'd0);
        chk("reset dout",  32'(dout),  32'd0);
        chk("reset empty", 32'(empty), 32'd1);
        chk("reset flags", 32'({ovf, unf}), 32'd0);
        rst_n = 1'b1;

        // err_clr held high keeps expectations identical for pulse and sticky builds
        //               p  pp t  c  din    dout   cnt e  f  ovf unf
        tbl.push_back(mk(0, 0, 1, 1, 8'h00, 8'h00, 0, 1, 0, 0, 1)); // tos on empty
        tbl.push_back(mk(1, 0, 0, 1, 8'h11, 8'h00, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 8'h22, 8'h00, 2, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 8'h33, 8'h00, 3, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 8'h00, 8'h33, 2, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 8'h00, 8'h22, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 8'h00, 8'h11, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 8'h00, 8'h11, 0, 1, 0, 0, 0)); // dout holds
        tbl.push_back(mk(0, 1, 0, 1, 8'h00, 8'h11, 0, 1, 0, 0, 1)); // pop on empty
        tbl.push_back(mk(1, 1, 0, 1, 8'h44, 8'h11, 1, 0, 0, 0, 1)); // replace on empty
        tbl.push_back(mk(1, 0, 0, 1, 8'h22, 8'h11, 2, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 1, 8'h55, 8'h22, 2, 0, 0, 0, 0)); // replace top
        tbl.push_back(mk(0, 0, 1, 1, 8'h00, 8'h55, 2, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 1, 8'h66, 8'h55, 3, 0, 0, 0, 0)); // tos ignored with push
        tbl.push_back(mk(0, 1, 1, 1, 8'h00, 8'h66, 2, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 8'h00, 8'h55, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 8'h00, 8'h44, 0, 1, 0, 0, 0));
        foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

        // Fill to full, overflow, then pop last legal value
        do_reset();
        for (int i = 1; i <= DEPTH; i++) begin
            step(mk(1, 0, 0, 1, DW'(8'h10 + i), 8'h00, i, 0, (i == DEPTH), 0, 0),
                 $sformatf("fill%0d", i));
        end
        step(mk(1, 0, 0, 1, 8'hAA, 8'h00, DEPTH, 0, 1, 1, 0), "ovf push");
        step(mk(1, 1, 0, 1, 8'hBB, 8'h20, DEPTH, 0, 1, 0, 0), "replace when full");
        step(mk(0, 1, 0, 1, 8'h00, 8'hBB, DEPTH - 1, 0, 0, 0, 0), "pop after full");
        step(mk(0, 1, 0, 1, 8'h00, 8'h1F, DEPTH - 2, 0, 0, 0, 0), "pop below");

        // Asynchronous reset mid-sequence with count=5
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            step(mk(1, 0, 0, 1, DW'(8'h70 + i), 8'h00, i, 0, 0, 0, 0), $sformatf("pre%0d", i));
        end
        step(mk(0, 1, 0, 1, 8'h00, 8'h76, 5, 0, 0, 0, 0), "pre pop");
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst count", 32'(count), 32'd0);
        chk("async rst dout",  32'(dout),  32'd0);
        chk("async rst empty", 32'(empty), 32'd1);
        chk("async rst flags", 32'({ovf, unf}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(mk(0, 0, 1, 1, 8'h00, 8'h00, 0, 1, 0, 0, 1), "tos after rst");

`ifdef OPSTACK_ERR_STICKY_EN
        step(mk(0, 1, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0, 1), "sticky evt");
        for (int i = 0; i < 3; i++) begin
            step(mk(0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0, 1), $sformatf("sticky idle%0d", i));
        end
        step(mk(0, 0, 0, 1, 8'h00, 8'h00, 0, 1, 0, 0, 0), "sticky clr");
        step(mk(0, 1, 0, 1, 8'h00, 8'h00, 0, 1, 0, 0, 1), "clr with evt");
        step(mk(0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0, 1), "sticky hold");
`else
        step(mk(0, 1, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0, 1), "pulse evt");
        step(mk(0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0), "pulse drop");
        step(mk(0, 0, 1, 0, 8'h00, 8'h00, 0, 1, 0, 0, 1), "pulse tos");
        step(mk(0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0), "pulse drop2");
`endif

        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard leftover: got %0d entries expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule
